io_input_conditioner: RTL and testbench

//  Conditions the raw board inputs before they reach the MIPS top level.

---
 rtl/io_pkg.sv | 33 +++
 rtl/debounce_cell.sv | 92 +++++++++
 rtl/io_input_conditioner.sv | 90 +++++++++
 tb/tb_io_input_conditioner.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// ---------------------------------------------------------------------------
// io_pkg
// Shared defaults for the board input conditioning logic.
//   DEFAULT_DEBOUNCE_CYCLES : stability window (10 ms at 50 MHz)
//   DEFAULT_SYNC_STAGES     : synchronizer depth per input bit
//   NUM_BUTTONS_DE10        : push buttons on the DE10 board
//   NUM_SWITCHES_DE10       : slide switches on the DE10 board
//   debounce_cnt_width(n)   : counter width able to hold the value n
// ---------------------------------------------------------------------------
package io_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int NUM_BUTTONS_DE10        = 2;
    localparam int NUM_SWITCHES_DE10       = 10;

    // Width of an unsigned counter that can represent 0..n; never narrower than one bit.
    function automatic int debounce_cnt_width(input int n);
        int w;
        if (n < 1) begin
            w = 1;
        end else begin
            w = $clog2(n + 1);
        end
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage : io_pkg

// File: rtl/debounce_cell.sv
// ---------------------------------------------------------------------------
// debounce_cell
// One input bit: synchronizer chain, stability counter and accepted-value flop.
// The bit entering raw_in is already active-high (button polarity is fixed up
// by the parent), so RESET_VAL is the idle level seen on the chain after reset.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-low reset
//   raw_in       in   unsynchronized input bit
//   stable_out   out  debounced value (flop)
//   rise_pulse   out  one-cycle flop pulse on the edge stable_out goes 0->1
//   update_pulse out  strobe in the cycle *before* stable_out changes; the
//                     parent registers an OR of these so its change flag
//                     lands on the same edge as the value update
// ---------------------------------------------------------------------------
module debounce_cell
    import io_pkg::*;
#(
    parameter int   SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic stable_out,
    output logic rise_pulse,
    output logic update_pulse
);

    localparam int              CNT_W    = debounce_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   stable_r;
    logic                   rise_r;
    logic                   synced_s;
    logic                   differ_s;
    logic                   expire_s;

    assign synced_s = sync_r[SYNC_STAGES-1];

    // Decide whether the candidate value has now been stable long enough.
    always_comb begin
        differ_s = 1'b0;
        expire_s = 1'b0;
        if (synced_s != stable_r) begin
            differ_s = 1'b1;
            expire_s = (cnt_r == CNT_LAST);
        end else begin
            differ_s = 1'b0;
            expire_s = 1'b0;
        end
    end

    // Synchronizer shift register; bit 0 is the metastable capture stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw_in};
        end
    end

    // Stability counter and accepted value; any return to the old value restarts the window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r    <= CNT_ZERO;
            stable_r <= 1'b0;
            rise_r   <= 1'b0;
        end else if (!differ_s) begin
            cnt_r    <= CNT_ZERO;
            rise_r   <= 1'b0;
        end else if (expire_s) begin
            cnt_r    <= CNT_ZERO;
            stable_r <= synced_s;
            rise_r   <= synced_s;
        end else begin
            cnt_r    <= cnt_r + CNT_ONE;
            rise_r   <= 1'b0;
        end
    end

    assign stable_out   = stable_r;
    assign rise_pulse   = rise_r;
    assign update_pulse = expire_s;

endmodule : debounce_cell

// File: rtl/io_input_conditioner.sv
// ---------------------------------------------------------------------------
// io_input_conditioner
// Synchronizes and debounces the raw board buttons and switches before they
// reach the CPU top level, so contact bounce cannot cause repeated inport loads.
//
// Ports
//   clk              in   rising-edge clock
//   rst              in   asynchronous, active-low reset
//   buttons_raw      in   button pins (unsynchronized)
//   switches_raw     in   switch pins (unsynchronized)
//   buttons_level    out  debounced button state, 1 = pressed
//   buttons_pulse    out  one-cycle pulse per accepted press
//   switches_stable  out  debounced switch values
//   switches_changed out  one-cycle pulse on any edge a switch value updates
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module io_input_conditioner
    import io_pkg::*;
#(
    parameter int NUM_BUTTONS       = NUM_BUTTONS_DE10,
    parameter int NUM_SWITCHES      = NUM_SWITCHES_DE10,
    parameter int SYNC_STAGES       = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int BUTTON_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_BUTTONS-1:0]  buttons_raw,
    input  logic [NUM_SWITCHES-1:0] switches_raw,
    output logic [NUM_BUTTONS-1:0]  buttons_level,
    output logic [NUM_BUTTONS-1:0]  buttons_pulse,
    output logic [NUM_SWITCHES-1:0] switches_stable,
    output logic                    switches_changed
);

    logic [NUM_BUTTONS-1:0]  btn_norm_s;
    logic [NUM_BUTTONS-1:0]  btn_update_unused_s;
    logic [NUM_SWITCHES-1:0] sw_rise_unused_s;
    logic [NUM_SWITCHES-1:0] sw_update_s;
    logic                    sw_changed_r;

    // Buttons are flipped to active-high ahead of the synchronizer, so the
    // chain's idle (released) level is 0 and reset never looks like a press.
    generate
        for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
            assign btn_norm_s[i] = (BUTTON_ACTIVE_LOW != 0) ? ~buttons_raw[i] : buttons_raw[i];

            debounce_cell #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RESET_VAL       (1'b0)
            ) u_cell (
                .clk          (clk),
                .rst          (rst),
                .raw_in       (btn_norm_s[i]),
                .stable_out   (buttons_level[i]),
                .rise_pulse   (buttons_pulse[i]),
                .update_pulse (btn_update_unused_s[i])
            );
        end

        for (genvar j = 0; j < NUM_SWITCHES; j++) begin : g_sw
            debounce_cell #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RESET_VAL       (1'b0)
            ) u_cell (
                .clk          (clk),
                .rst          (rst),
                .raw_in       (switches_raw[j]),
                .stable_out   (switches_stable[j]),
                .rise_pulse   (sw_rise_unused_s[j]),
                .update_pulse (sw_update_s[j])
            );
        end
    endgenerate

    // Change flag: the cells' strobes lead their value update by one edge, so
    // registering the OR aligns the flag with the switches_stable update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_changed_r <= 1'b0;
        end else begin
            sw_changed_r <= |sw_update_s;
        end
    end

    assign switches_changed = sw_changed_r;

endmodule : io_input_conditioner

// File: tb/tb_io_input_conditioner.sv
module tb_io_input_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] buttons_raw = 2'b11;
    logic [9:0] switches_raw = 10'h000;
    logic [1:0] buttons_level;
    logic [1:0] buttons_pulse;
    logic [9:0] switches_stable;
    logic       switches_changed;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    always #5 clk = ~clk;

    io_input_conditioner #(
        .NUM_BUTTONS       (2),
        .NUM_SWITCHES      (10),
        .SYNC_STAGES       (2),
        .DEBOUNCE_CYCLES   (4),
        .BUTTON_ACTIVE_LOW (1)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .buttons_raw      (buttons_raw),
        .switches_raw     (switches_raw),
        .buttons_level    (buttons_level),
        .buttons_pulse    (buttons_pulse),
        .switches_stable  (switches_stable),
        .switches_changed (switches_changed)
    );

    logic [14:0] outs;
    assign outs = {buttons_level, buttons_pulse, switches_stable, switches_changed};

    typedef struct {
        logic [1:0]  btn;
        logic [9:0]  sw;
        int          waits;
        logic [14:0] exp;
    } vec_t;

    localparam int NV = 21;
    vec_t tbl [NV];

    function automatic logic [14:0] mk(input logic [1:0] lvl, input logic [1:0] pls,
                                       input logic [9:0] sws, input logic chg);
        return {lvl, pls, sws, chg};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic [14:0] exp);
        vec_cnt++;
        if (outs !== exp) begin
            miss_cnt++;
            $display("FAIL %s[%0d]: got lvl=%b pls=%b sw=%h chg=%b, want lvl=%b pls=%b sw=%h chg=%b",
                     name, idx, outs[14:13], outs[12:11], outs[10:1], outs[0],
                     exp[14:13], exp[12:11], exp[10:1], exp[0]);
        end
    endtask

    initial begin
        // press b0, exact 6-edge latency, single pulse
        tbl[0]  = '{2'b10, 10'h000, 5, mk(2'b00, 2'b00, 10'h000, 1'b0)};
        tbl[1]  = '{2'b10, 10'h000, 1, mk(2'b01, 2'b01, 10'h000, 1'b0)};
        tbl[2]  = '{2'b10, 10'h000, 1, mk(2'b01, 2'b00, 10'h000, 1'b0)};
        tbl[3]  = '{2'b10, 10'h000, 3, mk(2'b01, 2'b00, 10'h000, 1'b0)};
        // release b0: level drops at edge 6, no pulse
        tbl[4]  = '{2'b11, 10'h000, 5, mk(2'b01, 2'b00, 10'h000, 1'b0)};
        tbl[5]  = '{2'b11, 10'h000, 1, mk(2'b00, 2'b00, 10'h000, 1'b0)};
        tbl[6]  = '{2'b11, 10'h000, 2, mk(2'b00, 2'b00, 10'h000, 1'b0)};
        // switch step to 2A5
        tbl[7]  = '{2'b11, 10'h2A5, 5, mk(2'b00, 2'b00, 10'h000, 1'b0)};
        tbl[8]  = '{2'b11, 10'h2A5, 1, mk(2'b00, 2'b00, 10'h2A5, 1'b1)};
        tbl[9]  = '{2'b11, 10'h2A5, 1, mk(2'b00, 2'b00, 10'h2A5, 1'b0)};
        // bit 0 flips, then bit 9 three cycles later
        tbl[10] = '{2'b11, 10'h2A4, 3, mk(2'b00, 2'b00, 10'h2A5, 1'b0)};
        tbl[11] = '{2'b11, 10'h0A4, 2, mk(2'b00, 2'b00, 10'h2A5, 1'b0)};
        tbl[12] = '{2'b11, 10'h0A4, 1, mk(2'b00, 2'b00, 10'h2A4, 1'b1)};
        tbl[13] = '{2'b11, 10'h0A4, 1, mk(2'b00, 2'b00, 10'h2A4, 1'b0)};
        tbl[14] = '{2'b11, 10'h0A4, 1, mk(2'b00, 2'b00, 10'h2A4, 1'b0)};
        tbl[15] = '{2'b11, 10'h0A4, 1, mk(2'b00, 2'b00, 10'h0A4, 1'b1)};
        tbl[16] = '{2'b11, 10'h0A4, 1, mk(2'b00, 2'b00, 10'h0A4, 1'b0)};
        // both buttons pressed together pulse on the same edge
        tbl[17] = '{2'b00, 10'h0A4, 5, mk(2'b00, 2'b00, 10'h0A4, 1'b0)};
        tbl[18] = '{2'b00, 10'h0A4, 1, mk(2'b11, 2'b11, 10'h0A4, 1'b0)};
        tbl[19] = '{2'b00, 10'h0A4, 1, mk(2'b11, 2'b00, 10'h0A4, 1'b0)};
        tbl[20] = '{2'b11, 10'h0A4, 6, mk(2'b00, 2'b00, 10'h0A4, 1'b0)};

        // reset with idle inputs, then 20 quiet cycles
        rst = 1'b0;
        buttons_raw = 2'b11;
        switches_raw = 10'h000;
        repeat (3) tick();
        check("in_reset", 0, mk(2'b00, 2'b00, 10'h000, 1'b0));
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("idle", k, mk(2'b00, 2'b00, 10'h000, 1'b0));
        end

        for (int i = 0; i < NV; i++) begin
            buttons_raw  = tbl[i].btn;
            switches_raw = tbl[i].sw;
            repeat (tbl[i].waits) tick();
            check("table", i, tbl[i].exp);
        end

        // b1 bounces every 2 cycles for 20 cycles, then settles pressed
        for (int k = 0; k < 10; k++) begin
            buttons_raw = {((k % 2) == 0) ? 1'b0 : 1'b1, 1'b1};
            repeat (2) begin
                tick();
                check("bounce", k, mk(2'b00, 2'b00, 10'h0A4, 1'b0));
            end
        end
        buttons_raw = 2'b01;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("settle_wait", k, mk(2'b00, 2'b00, 10'h0A4, 1'b0));
        end
        tick();
        check("settle_edge", 6, mk(2'b10, 2'b10, 10'h0A4, 1'b0));
        for (int k = 0; k < 4; k++) begin
            tick();
            check("settle_hold", k, mk(2'b10, 2'b00, 10'h0A4, 1'b0));
        end

        // press b0 partway into its window, then reset with raw idle
        buttons_raw = 2'b00;
        repeat (4) tick();
        check("pre_reset", 0, mk(2'b10, 2'b00, 10'h0A4, 1'b0));
        rst = 1'b0;
        buttons_raw = 2'b11;
        switches_raw = 10'h000;
        #1;
        check("async_reset", 0, mk(2'b00, 2'b00, 10'h000, 1'b0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("post_reset", k, mk(2'b00, 2'b00, 10'h000, 1'b0));
        end
        buttons_raw = 2'b10;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("repress_wait", k, mk(2'b00, 2'b00, 10'h000, 1'b0));
        end
        tick();
        check("repress_edge", 6, mk(2'b01, 2'b01, 10'h000, 1'b0));
        tick();
        check("repress_hold", 7, mk(2'b01, 2'b00, 10'h000, 1'b0));
        buttons_raw = 2'b11;
        repeat (8) tick();
        check("release_all", 0, mk(2'b00, 2'b00, 10'h000, 1'b0));

        // switches already nonzero while reset is held
        rst = 1'b0;
        switches_raw = 10'h155;
        #1;
        check("sw_in_reset", 0, mk(2'b00, 2'b00, 10'h000, 1'b0));
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("sw_rst_wait", k, mk(2'b00, 2'b00, 10'h000, 1'b0));
        end
        tick();
        check("sw_rst_edge", 6, mk(2'b00, 2'b00, 10'h155, 1'b1));
        tick();
        check("sw_rst_hold", 7, mk(2'b00, 2'b00, 10'h155, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule : tb_io_input_conditioner
